dp_group_feeder: RTL and testbench
==================================

Name: dp_group_feeder

Overview:
- Operand sequencer driving one dot-product group (N_UNIT units, N_MUL 8-bit lanes each).
- Host writes a tile of A vectors and matching B vector-sets into a local buffer; a start pulse streams them out, one beat per cycle.
- Produces the group's enable, in_a, in_b and in_valid, then drains the downstream pipeline and reports completion.

Parameters:
- N_UNIT, 4, dot-product units in the driven group
- N_MUL, 4, multipliers per unit
- DW_MUL, 8, operand width
- DW_UNIT_IN, DW_MUL*N_MUL, width of one A vector / one B vector
- DEPTH, 16, buffer entries (max beats per run), power of 2
- AW, 4, log2(DEPTH)
- DRAIN_CYC, 3, downstream pipeline latency in cycles to flush after last beat

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  buffer write strobe
- wr_addr  in  AW  buffer entry index
- wr_a  in  DW_UNIT_IN  A vector for entry
- wr_b  in  N_UNIT*DW_UNIT_IN  B vectors for entry (unit i at bits [(i+1)*DW_UNIT_IN-1 : i*DW_UNIT_IN])
- start  in  1  run request pulse
- len  in  AW+1  beats to stream, sampled with start
- hold  in  1  backpressure: freeze streaming
- busy  out  1  run in progress (not IDLE)
- done  out  1  one-cycle completion pulse
- enable  out  1  to group enable
- out_a  out  DW_UNIT_IN  to group in_a
- out_b  out  N_UNIT*DW_UNIT_IN  to group in_b
- out_valid  out  2  to group in_valid: [0]=beat valid, [1]=last beat of run

Behaviour:
- Reset: state IDLE, rd pointer 0, beat count 0; busy=0, done=0, enable=0, out_valid=0, out_a=0, out_b=0. Buffer contents not cleared. Reset mid-run aborts immediately; no done pulse.
- All outputs registered.
- Buffer write: wr_en accepted only in IDLE; writes in other states are ignored (entry unchanged). Write at cycle t readable by a start at t+1 or later.
- States: IDLE, STREAM, DRAIN, DONE.
- IDLE: start=1 samples len. Effective length L = min(len, DEPTH). L=0 -> DONE directly, no beats. Else -> STREAM, pointer=0. start outside IDLE ignored.
- STREAM: each cycle with hold=0 presents entry[pointer] on out_a/out_b, out_valid[0]=1, enable=1, pointer++. Beat with pointer=L-1 also sets out_valid[1]=1, then -> DRAIN. First beat appears the cycle after start is sampled (1-cycle latency). hold=1: enable=0, out_valid=00, out_a/out_b hold last values, pointer frozen; streaming resumes on the same entry when hold drops.
- DRAIN: DRAIN_CYC cycles with enable=1, out_valid=00 (hold ignored in DRAIN), then -> DONE.
- DONE: done=1 for exactly one cycle, enable=0, -> IDLE. busy=1 in STREAM, DRAIN, DONE.
- start and wr_en both high in IDLE: write performed and run started; the run reads the new entry value only if wr_addr is not read at beat 0 (beat 0 reads pre-write data for that entry).
- No wrap-around: pointer never exceeds L-1.

Test Plan:
- Write entries 0..3 with wr_a=0x01020304+i and distinct wr_b; start len=4, hold=0 -> beats at start+1..start+4 carry entries 0..3, out_valid=01,01,01,11; enable=1 for 4+3 cycles; done pulses at start+8; busy low at start+9.
- Same run with hold=1 on cycles start+2..start+3 -> entry 1 presented twice-stalled (out_valid=00, enable=0 during hold), all 4 beats delivered in order, done at start+10.
- start len=0 -> no beats, enable never high, done at start+1.
- start len=20 -> clamped to 16 beats; last flag on entry 15.
- wr_en to entry 2 with value X during STREAM -> ignored; next run reads original entry 2.
- reset asserted in DRAIN -> next cycle all outputs 0, busy=0, no done pulse; a subsequent start len=1 completes normally.

Source files
------------

// File: rtl/dp_group_feeder.sv
// Operand sequencer for one dot-product group: buffers a tile of A/B
// vectors, streams one beat per cycle on start, drains, then pulses done.
module dp_group_feeder #(
  parameter int N_UNIT     = 4,
  parameter int N_MUL      = 4,
  parameter int DW_MUL     = 8,
  parameter int DW_UNIT_IN = DW_MUL * N_MUL,
  parameter int DEPTH      = 16,
  parameter int AW         = 4,
  parameter int DRAIN_CYC  = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [AW-1:0]                wr_addr,
  input  logic [DW_UNIT_IN-1:0]        wr_a,
  input  logic [N_UNIT*DW_UNIT_IN-1:0] wr_b,
  input  logic                         start,
  input  logic [AW:0]                  len,
  input  logic                         hold,
  output logic                         busy,
  output logic                         done,
  output logic                         enable,
  output logic [DW_UNIT_IN-1:0]        out_a,
  output logic [N_UNIT*DW_UNIT_IN-1:0] out_b,
  output logic [1:0]                   out_valid
);

  localparam int BW = N_UNIT * DW_UNIT_IN;
  localparam int CW = $clog2(DRAIN_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [DW_UNIT_IN-1:0] mem_a [DEPTH];
  logic [BW-1:0]         mem_b [DEPTH];

  logic [AW-1:0]         ptr_q, ptr_d;
  logic [AW-1:0]         last_q, last_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DW_UNIT_IN-1:0] stg_a_q, stg_a_d;
  logic [BW-1:0]         stg_b_q, stg_b_d;

  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  enable_q, enable_d;
  logic [DW_UNIT_IN-1:0] out_a_q, out_a_d;
  logic [BW-1:0]         out_b_q, out_b_d;
  logic [1:0]            out_valid_q, out_valid_d;

  logic [AW:0]           len_eff;
  logic [AW-1:0]         nxt_ptr;
  logic                  is_last;

  always_ff @(posedge clk) begin
    if (wr_en && state_q == S_IDLE) begin
      mem_a[wr_addr] <= wr_a;
      mem_b[wr_addr] <= wr_b;
    end
  end

  assign len_eff = (len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len;
  assign nxt_ptr = ptr_q + 1'b1;
  assign is_last = (ptr_q == last_q);

  // Staging holds the entry for the next beat; loading entry 0 at start
  // is what makes a same-cycle write to entry 0 invisible to beat 0.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    stg_a_d     = stg_a_q;
    stg_b_d     = stg_b_q;
    done_d      = 1'b0;
    enable_d    = 1'b0;
    out_valid_d = 2'b00;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          if (len_eff == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_STREAM;
            ptr_d   = '0;
            last_d  = AW'(len_eff - 1'b1);
            stg_a_d = mem_a[0];
            stg_b_d = mem_b[0];
          end
        end
      end
      S_STREAM: begin
        if (!hold) begin
          out_a_d     = stg_a_q;
          out_b_d     = stg_b_q;
          out_valid_d = {is_last, 1'b1};
          enable_d    = 1'b1;
          ptr_d       = nxt_ptr;
          stg_a_d     = mem_a[nxt_ptr];
          stg_b_d     = mem_b[nxt_ptr];
          if (is_last) begin
            state_d = S_DRAIN;
            cnt_d   = '0;
          end
        end
      end
      S_DRAIN: begin
        enable_d = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(DRAIN_CYC - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE) || (state_q == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      last_q      <= '0;
      cnt_q       <= '0;
      stg_a_q     <= '0;
      stg_b_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      enable_q    <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_valid_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      stg_a_q     <= stg_a_d;
      stg_b_q     <= stg_b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      enable_q    <= enable_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign enable    = enable_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_dp_group_feeder.sv
// Scoreboard bench for dp_group_feeder: stimulus pushes expected beats and
// done pulses with their cycle numbers, a negedge monitor pops and compares.
module tb_dp_group_feeder;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int DWU   = 32;
  localparam int BW    = 128;

  logic           clk = 1'b0;
  logic           reset;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [DWU-1:0] wr_a;
  logic [BW-1:0]  wr_b;
  logic           start;
  logic [AW:0]    len;
  logic           hold;
  logic           busy;
  logic           done;
  logic           enable;
  logic [DWU-1:0] out_a;
  logic [BW-1:0]  out_b;
  logic [1:0]     out_valid;

  dp_group_feeder dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_a      (wr_a),
    .wr_b      (wr_b),
    .start     (start),
    .len       (len),
    .hold      (hold),
    .busy      (busy),
    .done      (done),
    .enable    (enable),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             cyc;
    bit             is_done;
    logic [DWU-1:0] a;
    logic [BW-1:0]  b;
    bit             last;
    int             en;
  } exp_t;

  exp_t           q[$];
  int             cyc = 0;
  int             n_chk = 0;
  int             n_fail = 0;
  int             en_cnt = 0;
  logic [DWU-1:0] ma [DEPTH];
  logic [BW-1:0]  mb [DEPTH];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(int c, bit d, logic [DWU-1:0] a,
                              logic [BW-1:0] b, bit last, int en);
    exp_t e;
    e.cyc = c; e.is_done = d; e.a = a; e.b = b; e.last = last; e.en = en;
    return e;
  endfunction

  // Monitor: every beat or done pulse must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    if (reset) begin
      en_cnt = 0;
    end else begin
      if (enable) en_cnt++;
      if (out_valid[0] || done) begin
        n_chk++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output cyc=%0d valid=%b done=%b",
                   cyc, out_valid, done);
        end else begin
          e = q.pop_front();
          if (e.is_done)
            ok = done && out_valid == 2'b00 && !enable && busy &&
                 cyc == e.cyc && en_cnt == e.en;
          else
            ok = !done && out_valid == {e.last, 1'b1} && enable && busy &&
                 cyc == e.cyc && out_a == e.a && out_b == e.b;
          if (!ok) begin
            n_fail++;
            $display("FAIL %s cyc=%0d want_cyc=%0d valid=%b want_last=%0d done=%b busy=%b a=%h want_a=%h b=%h want_b=%h en_cnt=%0d want_en=%0d",
                     e.is_done ? "done" : "beat", cyc, e.cyc, out_valid,
                     e.last, done, busy, out_a, e.a, out_b, e.b, en_cnt, e.en);
          end
        end
        if (done) en_cnt = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wr(input int addr, input logic [DWU-1:0] a,
                    input logic [BW-1:0] b);
    wr_en = 1'b1; wr_addr = addr[AW-1:0]; wr_a = a; wr_b = b;
    step();
    wr_en = 1'b0;
    ma[addr] = a; mb[addr] = b;
  endtask

  // hm bit k: hold driven for edge s+k; wr_at: edge offset of a stray write.
  task automatic run(input int ln, input logic [31:0] hm, input int wr_at);
    int s, e, l, dc;
    l = (ln > DEPTH) ? DEPTH : ln;
    s = cyc + 1;
    start = 1'b1;
    len = ln[AW:0];
    if (l == 0) begin
      dc = s + 1;
      q.push_back(mk(dc, 1'b1, '0, '0, 1'b0, 0));
    end else begin
      e = s + 1;
      for (int k = 0; k < l; k++) begin
        while (hm[e - s]) e++;
        q.push_back(mk(e, 1'b0, ma[k], mb[k], k == l - 1, 0));
        e++;
      end
      dc = e + 3;
      q.push_back(mk(dc, 1'b1, '0, '0, 1'b0, l + 3));
    end
    step();
    start = 1'b0;
    while (cyc < dc) begin
      hold  = hm[cyc + 1 - s];
      wr_en = (cyc + 1 - s == wr_at);
      wr_addr = 4'd2;
      wr_a  = 32'hDEADBEEF;
      wr_b  = {4{32'hDEADBEEF}};
      step();
    end
    hold = 1'b0;
    wr_en = 1'b0;
    check("busy_at_done", 256'(busy), 256'(1));
    step();
    check("busy_after_done", 256'(busy), 256'(0));
  endtask

  initial begin
    int s;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_a = '0; wr_b = '0;
    start = 1'b0; len = '0; hold = 1'b0;
    step();
    step();
    check("reset_outputs",
          256'({busy, done, enable, out_valid, out_a, out_b}), 256'(0));
    reset = 1'b0;

    for (int i = 0; i < DEPTH; i++)
      wr(i, 32'h01020304 + i,
         {32'hB3000000 | i, 32'hB2000000 | i, 32'hB1000000 | i,
          32'hB0000000 | i});

    run(4, 32'h0, 0);
    run(4, 32'h0000000C, 0);
    run(0, 32'h0, 0);
    run(20, 32'h0, 0);
    run(4, 32'h0, 3);
    run(4, 32'h0, 0);

    // Same-cycle write to entry 0 with start: beat 0 still sees old data.
    wr_en = 1'b1; wr_addr = '0; wr_a = 32'hCAFE0000; wr_b = {4{32'hCAFE0000}};
    run(2, 32'h0, 0);
    ma[0] = 32'hCAFE0000; mb[0] = {4{32'hCAFE0000}};
    run(1, 32'h0, 0);

    // Reset while draining aborts the run with no done pulse.
    s = cyc + 1;
    start = 1'b1; len = 5'd2;
    q.push_back(mk(s + 1, 1'b0, ma[0], mb[0], 1'b0, 0));
    q.push_back(mk(s + 2, 1'b0, ma[1], mb[1], 1'b1, 0));
    step();
    start = 1'b0;
    step(); step(); step();
    reset = 1'b1;
    step();
    check("reset_in_drain",
          256'({busy, done, enable, out_valid, out_a, out_b}), 256'(0));
    reset = 1'b0;
    step(); step();
    run(1, 32'h0, 0);

    step(); step();
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_outputs: got %0d pending want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
